// File: rtl/npc_wb_pkg.sv
// Shared write-back definitions for the NPC register-file write port.
// Holds the requester indices, the request payload type and the pointer helper.
package npc_wb_pkg;

  localparam int NREQ      = 3;
  localparam int REQ_EXU   = 0;
  localparam int REQ_LSU   = 1;
  localparam int REQ_CSR   = 2;

  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Round-robin pointer moves to the requester just after the winner.
  function automatic int nextRrPtr(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first valid index at or after ptr wins.
// The grant is one-hot (or all-zero when disabled or nothing is valid).
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic          enable_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grantIdx_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    found      = 1'b0;
    idx        = '0;
    for (int off = 0; off < N; off++) begin
      idx = PW'((int'(ptr_i) + off) % N);
      if (enable_i && !found && valid_i[idx]) begin
        found       = 1'b1;
        grant_o[idx] = 1'b1;
        grantIdx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin sharing of the register-file write port between EXU, LSU and CSR.
// The winning write is staged for one cycle; x0 writes are acknowledged but dropped.
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = npc_wb_pkg::WB_ADDR_W,
  parameter int DATA_WIDTH = npc_wb_pkg::WB_DATA_W,
  parameter int NREQ       = npc_wb_pkg::NREQ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic                       wb_stall,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [1:0]                 wb_grant_id,
  output logic [31:0]                wb_commit_cnt
);

  import npc_wb_pkg::*;

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]      rrPtr_q, rrPtr_d;
  logic [NREQ-1:0]       grant;
  logic [PTR_W-1:0]      grantIdx;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;

  logic                  stageWen_q, stageWen_d;
  logic [ADDR_WIDTH-1:0] stageAddr_q, stageAddr_d;
  logic [DATA_WIDTH-1:0] stageData_q, stageData_d;
  logic [PTR_W-1:0]      stageId_q, stageId_d;
  logic [31:0]           commitCnt_q, commitCnt_d;

  rr_arbiter #(.N(NREQ)) uArb (
    .valid_i    (req_valid),
    .enable_i   (~rst & ~wb_stall),
    .ptr_i      (rrPtr_q),
    .grant_o    (grant),
    .grantIdx_o (grantIdx)
  );

  assign req_ready = grant;
  assign handshake = |(req_valid & grant);

  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        selAddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        selData = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Stage addr/data keep their last value when idle; only the enable drops.
  always_comb begin
    rrPtr_d     = rrPtr_q;
    stageWen_d  = 1'b0;
    stageAddr_d = stageAddr_q;
    stageData_d = stageData_q;
    stageId_d   = stageId_q;
    commitCnt_d = commitCnt_q + 32'(stageWen_q);
    if (handshake) begin
      rrPtr_d     = PTR_W'(nextRrPtr(int'(grantIdx), NREQ));
      stageWen_d  = (selAddr != '0);
      stageAddr_d = selAddr;
      stageData_d = selData;
      stageId_d   = grantIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q     <= '0;
      stageWen_q  <= 1'b0;
      stageAddr_q <= '0;
      stageData_q <= '0;
      stageId_q   <= '0;
      commitCnt_q <= '0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      stageWen_q  <= stageWen_d;
      stageAddr_q <= stageAddr_d;
      stageData_q <= stageData_d;
      stageId_q   <= stageId_d;
      commitCnt_q <= commitCnt_d;
    end
  end

  assign rf_wen        = stageWen_q;
  assign rf_waddr      = stageAddr_q;
  assign rf_wdata      = stageData_q;
  assign wb_grant_id   = 2'(stageId_q);
  assign wb_commit_cnt = commitCnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios then randomized traffic.
// The driver predicts grants and expected writes; a monitor checks the write port.
module tb_rf_wb_arbiter;

  import npc_wb_pkg::*;

  localparam int NR = 3;

  typedef struct {
    wb_req_t    req;
    logic [1:0] id;
    int         due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req_valid;
  logic [2:0]    req_ready;
  logic [14:0]   req_addr;
  logic [95:0]   req_data;
  logic          wb_stall;
  logic          rf_wen;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [1:0]    wb_grant_id;
  logic [31:0]   wb_commit_cnt;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            mPtr = 0;
  logic [31:0]   monCnt = '0;
  logic          rstEdge = 1'b0;
  logic          started = 1'b0;
  logic          done = 1'b0;
  exp_t          scoreQ[$];

  logic [2:0]    pend;
  logic [4:0]    pAddr[NR];
  logic [31:0]   pData[NR];
  logic [2:0]    rv;
  logic [14:0]   ra;
  logic [95:0]   rd;
  logic          rs, rr;
  int            g;

  rf_wb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .wb_stall      (wb_stall),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .wb_grant_id   (wb_grant_id),
    .wb_commit_cnt (wb_commit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rstEdge = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle, predict the grant from the round-robin rule and queue the expected write.
  task automatic applyStimulus(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                               input logic st, input logic r, output int gOut);
    logic [2:0] expReady;
    exp_t       e;
    @(negedge clk);
    rst       = r;
    wb_stall  = st;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    #1;
    gOut     = -1;
    expReady = '0;
    if (!r && !st) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (mPtr + k) % NR;
        if (gOut < 0 && v[idx]) gOut = idx;
      end
    end
    if (gOut >= 0) begin
      expReady[gOut] = 1'b1;
      mPtr = (gOut + 1) % NR;
      if (a[gOut*5 +: 5] != 5'd0) begin
        e.req.addr = a[gOut*5 +: 5];
        e.req.data = d[gOut*32 +: 32];
        e.id       = 2'(gOut);
        e.due      = cyc + 1;
        scoreQ.push_back(e);
      end
    end
    if (r) mPtr = 0;
    checkOutput("reqReady", 64'(req_ready), 64'(expReady));
  endtask

  task automatic doReset();
    int gd;
    applyStimulus(3'b000, '0, '0, 1'b0, 1'b1, gd);
    pend = '0;
    @(posedge clk);
    #1;
    checkOutput("resetWenAddrId", {rf_wen, rf_waddr, wb_grant_id}, '0);
    checkOutput("resetDataCnt", {rf_wdata, wb_commit_cnt}, '0);
  endtask

  task automatic idle(input int n);
    int gd;
    for (int k = 0; k < n; k++) applyStimulus(3'b000, '0, '0, 1'b0, 1'b0, gd);
  endtask

  // Monitor: every cycle the write port must match the head of the queue or be idle.
  initial begin : monitor
    exp_t e;
    logic expWen;
    wait (started);
    while (!done) begin
      @(negedge clk);
      if (rstEdge) begin
        monCnt  = '0;
        rstEdge = 1'b0;
      end
      checkOutput("commitCnt", 64'(wb_commit_cnt), 64'(monCnt));
      expWen = (scoreQ.size() > 0) && (scoreQ[0].due == cyc);
      checkOutput("rfWen", 64'(rf_wen), 64'(expWen));
      if (expWen) begin
        e = scoreQ.pop_front();
        checkOutput("rfWrite", 64'({rf_waddr, rf_wdata, wb_grant_id}),
                    64'({e.req.addr, e.req.data, e.id}));
        monCnt = monCnt + 32'd1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    rst = 1'b1; wb_stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; pend = '0;
    doReset();
    started = 1'b1;

    applyStimulus(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 1'b0, 1'b0, g);
    idle(2);

    doReset();
    for (int k = 0; k < 6; k++)
      applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0, 1'b0, g);
    idle(2);

    applyStimulus(3'b001, '0, {64'd0, 32'h1234}, 1'b0, 1'b0, g);
    idle(2);

    doReset();
    for (int k = 0; k < 3; k++)
      applyStimulus(3'b101, {5'd9, 5'd0, 5'd8}, {32'hC5, 32'd0, 32'hE0}, 1'b1, 1'b0, g);
    applyStimulus(3'b101, {5'd9, 5'd0, 5'd8}, {32'hC5, 32'd0, 32'hE0}, 1'b0, 1'b0, g);
    applyStimulus(3'b100, {5'd9, 5'd0, 5'd8}, {32'hC5, 32'd0, 32'hE0}, 1'b0, 1'b0, g);
    idle(1);

    applyStimulus(3'b010, {5'd0, 5'd4, 5'd0}, {32'd0, 32'h44, 32'd0}, 1'b0, 1'b0, g);
    applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 1'b1, g);
    applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 1'b0, g);
    idle(2);

    @(posedge clk);
    #2;
    force dut.commitCnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.commitCnt_q;
    monCnt = 32'hFFFF_FFFF;
    applyStimulus(3'b001, {10'd0, 5'd7}, {64'd0, 32'h77}, 1'b0, 1'b0, g);
    idle(2);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i] && $urandom_range(9) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(1) == 1) begin
          pend[i]  = 1'b1;
          pAddr[i] = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom);
          pData[i] = $urandom;
        end
        rv[i]          = pend[i];
        ra[i*5 +: 5]   = pend[i] ? pAddr[i] : 5'($urandom);
        rd[i*32 +: 32] = pend[i] ? pData[i] : $urandom;
      end
      rs = ($urandom_range(5) == 0);
      rr = ($urandom_range(99) == 0);
      applyStimulus(rv, ra, rd, rs, rr, g);
      if (g >= 0) pend[g] = 1'b0;
      if (rr) pend = '0;
    end
    idle(3);

    done = 1'b1;
    checkOutput("queueEmpty", 64'(scoreQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the register file's single write port among the NPC's write-back requesters: EXU result, LSU load data and CSR read data. Each cycle it grants at most one request, chosen round-robin. It registers the winning write and drives the register file's write port one cycle later. Writes to x0 are acknowledged but suppressed, and a commit counter is kept for performance and difftest sync.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width
- NREQ, 3, number of requesters (index 0 = EXU, 1 = LSU, 2 = CSR)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  request i holds a pending write
- req_ready  out  NREQ  grant; the write is accepted on the edge where valid&ready is high
- req_addr  in  NREQ*ADDR_WIDTH  destination of requester i, packed at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NREQ*DATA_WIDTH  write data of requester i, packed the same way
- wb_stall  in  1  when high, no grants are issued
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- wb_grant_id  out  2  index of the requester whose write is on rf_* this cycle
- wb_commit_cnt  out  32  total non-x0 writes issued since reset

## Operation
- Grant is combinational from req_valid, rr_ptr and wb_stall.
  - The search starts at index rr_ptr and wraps modulo NREQ.
  - The first valid index wins.
  - req_ready is one-hot or all-zero.
- req_ready is forced to 0 while rst or wb_stall is high.
- Requesters hold valid, addr and data stable until they see ready. Deasserting valid without a handshake is allowed, and such a request is simply not granted.
- On a handshake for index g:
  - rr_ptr <= (g+1) mod NREQ.
  - The stage register captures addr, data and g.
  - stage_wen <= (addr != 0).
- With no handshake: stage_wen <= 0, rr_ptr holds, and the stage addr/data hold their last values.
- rf_wen, rf_waddr, rf_wdata and wb_grant_id are driven directly from the stage register. The register file always accepts, so there is no back-pressure on the output.
- An x0 write completes its handshake but never raises rf_wen and does not increment wb_commit_cnt.
- wb_commit_cnt increments by 1 on each edge where stage_wen is high. It wraps at 2^32 to 0.
- Arbitration state machine: none beyond rr_ptr. Each stage entry is VALID or EMPTY, with VALID = stage_wen.

## Timing
- Throughput: 1 write per cycle sustained.
- Latency, for a handshake at edge E (end of cycle N):
  - rf_wen is high during cycle N+1.
  - The register file updates at the end of N+1.
  - The new value is readable from cycle N+2.
- Fairness: a continuously valid requester is granted within NREQ cycles of its first valid cycle, provided wb_stall stays low.
- wb_stall rising in cycle N blocks the handshake in N. A write already in the stage still issues in N.
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, wb_grant_id=0, wb_commit_cnt=0, rr_ptr=0, req_ready=0.
- Reset mid-operation: a write held in the stage at the reset edge is discarded (rf_wen=0 next cycle). Requesters must re-present their requests after reset.
- Simultaneous valid on all requesters with rr_ptr=0 gives grant order 0,1,2,0,...

## Structure
- Shared package npc_wb_pkg holds:
  - localparams NREQ=3, REQ_EXU=0, REQ_LSU=1, REQ_CSR=2
  - a struct wb_req_t {addr, data} used by the requester units.
- Sub-module rr_arbiter, parameterised by N:
  - inputs: valid[N], enable, ptr
  - outputs: one-hot grant[N] and the encoded grant index.
- rf_wb_arbiter instantiates rr_arbiter and owns rr_ptr, the stage register and the counter.

## Test plan
- Reset, then LSU only valid with addr=5, data=0xDEADBEEF: req_ready[1]=1 in that cycle; the next cycle shows rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, wb_grant_id=1; wb_commit_cnt=1 after that.
- All three valid continuously for 6 cycles after reset, addrs 1,2,3: grants 0,1,2,0,1,2; rf_wen high for 6 consecutive cycles; wb_commit_cnt=6.
- EXU valid with addr=0, data=0x1234: req_ready[0]=1; rf_wen stays 0 the next cycle; wb_commit_cnt unchanged.
- wb_stall=1 for 3 cycles with EXU and CSR valid: req_ready=000 throughout. After the stall drops, EXU is granted first, then CSR.
- Handshake in cycle N with rst asserted in cycle N+1: rf_wen=0 in N+2, wb_commit_cnt=0, rr_ptr=0, so the next grant with all valid goes to index 0.
- Preload wb_commit_cnt near wrap by forcing 0xFFFFFFFF, then one non-x0 write: counter reads 0.
